// File: rtl/tug_pkg.sv
// Shared types and defaults for the tug-of-war match controller.
// Build option TUG_MATCH_AUTO_RESTART_EN is consumed by tug_match_ctrl.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY,
        POINT,
        HOLD,
        DONE
    } state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } side_t;

    localparam int DEFAULT_WIN_SCORE   = 7;
    localparam int DEFAULT_HOLD_CYCLES = 4;
    localparam int RESTART_CYCLES      = 64;

    // One timer covers both the between-round hold and the restart delay.
    function automatic int timer_width(input int hold_cycles);
        return (hold_cycles > RESTART_CYCLES) ? $clog2(hold_cycles) : $clog2(RESTART_CYCLES);
    endfunction

endpackage

// File: rtl/tug_hold_timer.sv
// Loadable down-counter with a zero flag.
// It is shared by the round hold and the auto-restart delay.
module tug_hold_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    // Load wins over decrement, and the counter parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tug_match_ctrl.sv
// Match controller: scores points, holds the playfield between rounds, declares the winner.
// Optional build macro TUG_MATCH_AUTO_RESTART_EN adds clear_scores and an automatic restart.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int SCORE_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_l,
    input  logic               key_r,
    input  logic               lit_l,
    input  logic               lit_r,
    output logic               inc_l,
    output logic               inc_r,
    output logic               field_reset,
    output logic               match_over,
    output logic               winner,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r
`ifdef TUG_MATCH_AUTO_RESTART_EN
    ,
    output logic               clear_scores
`endif
);

    localparam int TIMER_W = timer_width(HOLD_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
`ifdef TUG_MATCH_AUTO_RESTART_EN
    localparam logic [TIMER_W-1:0] RESTART_LOAD = TIMER_W'(RESTART_CYCLES - 1);
`endif

    state_t state;
    side_t  side;

    logic               win_l;
    logic               win_r;
    logic [SCORE_W-1:0] new_score;
    logic               final_point;
    logic               timer_load;
    logic               timer_dec;
    logic               timer_done;
    logic [TIMER_W-1:0] timer_value;

    assign win_l       = lit_l & key_l;
    assign win_r       = lit_r & key_r;
    assign new_score   = ((side == RIGHT) ? score_r : score_l) + SCORE_W'(1);
    assign final_point = (new_score == SCORE_W'(WIN_SCORE));

    // The hold only counts once field_reset is visible, so the playfield
    // sees exactly HOLD_CYCLES cycles of reset after each point.
    always_comb begin
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = HOLD_LOAD;
        case (state)
            POINT: begin
                timer_load = 1'b1;
`ifdef TUG_MATCH_AUTO_RESTART_EN
                if (final_point) begin
                    timer_value = RESTART_LOAD;
                end
`endif
            end
            HOLD: begin
                timer_dec = field_reset;
            end
            DONE: begin
`ifdef TUG_MATCH_AUTO_RESTART_EN
                if (timer_done) begin
                    timer_load = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    tug_hold_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .done       (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLAY;
            side        <= LEFT;
            inc_l       <= 1'b0;
            inc_r       <= 1'b0;
            field_reset <= 1'b0;
            match_over  <= 1'b0;
            winner      <= 1'b0;
            score_l     <= '0;
            score_r     <= '0;
`ifdef TUG_MATCH_AUTO_RESTART_EN
            clear_scores <= 1'b0;
`endif
        end else begin
            inc_l <= 1'b0;
            inc_r <= 1'b0;
`ifdef TUG_MATCH_AUTO_RESTART_EN
            clear_scores <= 1'b0;
`endif
            case (state)
                PLAY: begin
                    // Simultaneous wins mean the field is corrupt; nobody scores.
                    if (win_l ^ win_r) begin
                        state <= POINT;
                        side  <= win_r ? RIGHT : LEFT;
                    end
                end
                POINT: begin
                    if (side == RIGHT) begin
                        inc_r   <= 1'b1;
                        score_r <= new_score;
                    end else begin
                        inc_l   <= 1'b1;
                        score_l <= new_score;
                    end
                    if (final_point) begin
                        state      <= DONE;
                        match_over <= 1'b1;
                        winner     <= (side == RIGHT);
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    field_reset <= 1'b1;
                    if (field_reset && timer_done) begin
                        field_reset <= 1'b0;
                        state       <= PLAY;
                    end
                end
                DONE: begin
                    field_reset <= 1'b1;
`ifdef TUG_MATCH_AUTO_RESTART_EN
                    if (timer_done) begin
                        score_l      <= '0;
                        score_r      <= '0;
                        match_over   <= 1'b0;
                        winner       <= 1'b0;
                        clear_scores <= 1'b1;
                        state        <= HOLD;
                    end
`endif
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Scoreboard bench for tug_match_ctrl: directed points, ignored keys, reset mid-hold, full match.
// Connects clear_scores when built with TUG_MATCH_AUTO_RESTART_EN.
module tb_tug_match_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_l = 1'b0;
    logic       key_r = 1'b0;
    logic       lit_l = 1'b0;
    logic       lit_r = 1'b0;
    logic       inc_l;
    logic       inc_r;
    logic       field_reset;
    logic       match_over;
    logic       winner;
    logic [2:0] score_l;
    logic [2:0] score_r;
`ifdef TUG_MATCH_AUTO_RESTART_EN
    logic       clear_scores;
`endif

    typedef struct {
        bit side;
        int sl;
        int sr;
        bit mo;
        bit win;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    tug_match_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .key_l       (key_l),
        .key_r       (key_r),
        .lit_l       (lit_l),
        .lit_r       (lit_r),
        .inc_l       (inc_l),
        .inc_r       (inc_r),
        .field_reset (field_reset),
        .match_over  (match_over),
        .winner      (winner),
        .score_l     (score_l),
        .score_r     (score_r)
`ifdef TUG_MATCH_AUTO_RESTART_EN
        ,
        .clear_scores(clear_scores)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present keys and lights for one sampling edge, then release them.
    task automatic applyStimulus(input bit kl, input bit kr, input bit ll, input bit lr);
        @(negedge clk);
        key_l = kl;
        key_r = kr;
        lit_l = ll;
        lit_r = lr;
        @(negedge clk);
        key_l = 1'b0;
        key_r = 1'b0;
        lit_l = 1'b0;
        lit_r = 1'b0;
    endtask

    task automatic pushExpect(input bit s, input int sl, input int sr, input bit mo, input bit w);
        exp_t e;
        e.side = s;
        e.sl   = sl;
        e.sr   = sr;
        e.mo   = mo;
        e.win  = w;
        sb.push_back(e);
    endtask

    // Called at the negedge right after the winning key was sampled.
    task automatic measureHold(input string tag);
        int w = 0;
        int len = 0;
        while (!field_reset && w < 10) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, "_latency"}, w, 2);
        while (field_reset && len < 20) begin
            @(negedge clk);
            len++;
        end
        checkOutput({tag, "_hold_len"}, len, 4);
    endtask

    task automatic doPoint(input bit s, input int sl, input int sr, input string tag);
        pushExpect(s, sl, sr, 1'b0, 1'b0);
        if (s) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        else   applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        measureHold(tag);
    endtask

    // Monitor: every increment pulse must match the oldest expected point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inc_l || inc_r) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_inc", int'(inc_l) + int'(inc_r), 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("inc_both", int'(inc_l && inc_r), 0);
                    checkOutput("inc_side", int'(inc_r), int'(e.side));
                    checkOutput("sb_score_l", int'(score_l), e.sl);
                    checkOutput("sb_score_r", int'(score_r), e.sr);
                    checkOutput("sb_match_over", int'(match_over), int'(e.mo));
                    if (e.mo) checkOutput("sb_winner", int'(winner), int'(e.win));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_field_reset", int'(field_reset), 0);
        checkOutput("rst_match_over", int'(match_over), 0);
        checkOutput("rst_scores", int'({score_l, score_r}), 0);
        checkOutput("rst_inc", int'({inc_l, inc_r}), 0);
        reset = 1'b0;

        $display("[TB] right point");
        doPoint(1'b1, 0, 1, "right1");
        checkOutput("right1_score_r", int'(score_r), 1);

        $display("[TB] key without its light");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("unlit_score_l", int'(score_l), 0);
        checkOutput("unlit_field_reset", int'(field_reset), 0);

        $display("[TB] both sides at once");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("both_scores", int'({score_l, score_r}), 1);
        checkOutput("both_field_reset", int'(field_reset), 0);

        $display("[TB] keys during hold");
        pushExpect(1'b0, 1, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            key_l = 1'b1; lit_l = 1'b1; key_r = 1'b1; lit_r = 1'b1;
            @(negedge clk);
        end
        key_l = 1'b0; lit_l = 1'b0; key_r = 1'b0; lit_r = 1'b0;
        for (int i = 0; i < 10 && field_reset; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("hold_keys_score_l", int'(score_l), 1);
        checkOutput("hold_keys_score_r", int'(score_r), 1);

        $display("[TB] reset during hold");
        doPoint(1'b1, 1, 2, "right2");
        doPoint(1'b1, 1, 3, "right3");
        pushExpect(1'b0, 2, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_field_reset", int'(field_reset), 1);
        checkOutput("pre_rst_score_r", int'(score_r), 3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_field_reset", int'(field_reset), 0);
        checkOutput("midrst_score_r", int'(score_r), 0);
        checkOutput("midrst_score_l", int'(score_l), 0);
        reset = 1'b0;
        doPoint(1'b1, 0, 1, "after_rst");

        $display("[TB] full match to left");
        for (int i = 1; i < 7; i++) doPoint(1'b0, i, 1, "left_run");
        pushExpect(1'b0, 7, 1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("done_match_over", int'(match_over), 1);
        checkOutput("done_winner", int'(winner), 0);
        checkOutput("done_field_reset", int'(field_reset), 1);
        checkOutput("done_score_l", int'(score_l), 7);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("frozen_score_l", int'(score_l), 7);
        checkOutput("frozen_score_r", int'(score_r), 1);
        checkOutput("frozen_match_over", int'(match_over), 1);
        checkOutput("sb_drained", sb.size(), 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tug_match_ctrl.md
Name: tug_match_ctrl

Overview:
Match controller for the two-player key-race game. Watches the two player keys and the two playfield edge lights, and decides which player scores a point. It emits one-cycle increment pulses to the per-player 7-segment score counters and holds the playfield in reset between rounds. It keeps shadow scores so it can declare the match winner at WIN_SCORE; it sits between the playfield FSM and the two score counters.

Parameters:
WIN_SCORE, 7, point total that ends the match; range 1..7, matching the counter display ceiling.
HOLD_CYCLES, 4, number of cycles field_reset stays asserted after a non-final point; must be at least 1.
SCORE_W, 3, shadow score width; equals clog2(WIN_SCORE+1).

Ports:
clk  in  1  system clock; every port is synchronous to it.
reset  in  1  synchronous, active-high reset.
key_l  in  1  left key press, already one-cycle edge-detected.
key_r  in  1  right key press, already one-cycle edge-detected.
lit_l  in  1  leftmost playfield light is on; the left player is at the winning edge.
lit_r  in  1  rightmost playfield light is on; the right player is at the winning edge.
inc_l  out  1  one-cycle pulse: left score counter increments.
inc_r  out  1  one-cycle pulse: right score counter increments.
field_reset  out  1  holds the playfield FSM in its centre/start state.
match_over  out  1  high once a player reaches WIN_SCORE.
winner  out  1  0 = left, 1 = right; valid only while match_over = 1.
score_l  out  SCORE_W  left shadow score.
score_r  out  SCORE_W  right shadow score.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state PLAY, and inc_l, inc_r, field_reset, match_over, winner, score_l, score_r, hold_cnt all 0.
- All outputs are registered.
- Point detection in PLAY:
  - win_l = lit_l & key_l
  - win_r = lit_r & key_r
- States:
  - PLAY:
    - win_l & ~win_r -> POINT, latch side = 0.
    - win_r & ~win_l -> POINT, latch side = 1.
    - Both true (illegal field state) -> stay in PLAY, no point.
    - Neither true -> stay in PLAY.
    - A key press without its light lit is ignored.
  - POINT: exactly 1 cycle.
    - Assert inc_<side> for this cycle only.
    - Increment score_<side>.
    - If the new score equals WIN_SCORE -> DONE, set winner = side.
    - Otherwise -> HOLD, load hold_cnt = HOLD_CYCLES-1.
  - HOLD:
    - field_reset = 1.
    - All keys and lights are ignored.
    - hold_cnt decrements each cycle.
    - When hold_cnt = 0 -> PLAY; field_reset drops on the cycle PLAY is entered.
  - DONE:
    - match_over = 1 and field_reset = 1, held.
    - No inc pulses, and scores are frozen.
    - Exit only via reset (or AUTO_RESTART_EN).
- Latency: a winning key seen at edge N gives inc_x high in cycle N+1 to N+2, and field_reset high from edge N+2.
- Point spacing: inc pulses are separated by at least HOLD_CYCLES+2 cycles.
- Saturation: scores never exceed WIN_SCORE; the inc pulse count per side equals score_x.
- Reset mid-operation (POINT, HOLD or DONE): returns to PLAY on the next edge with all outputs at reset values. Reset has priority over every other event.

Optional Feature:
Macro: TUG_MATCH_AUTO_RESTART_EN.
- Defined:
  - DONE lasts 64 cycles (RESTART_CYCLES localparam), counted in a 6-bit counter.
  - Then the block clears score_l, score_r, match_over and winner.
  - It then asserts clear_scores (extra 1-bit output port) for exactly 1 cycle, so the score counters return to zero, and enters HOLD.
- Undefined:
  - DONE is terminal until reset.
  - The clear_scores port does not exist.

Decomposition:
- Package tug_pkg:
  - state enum (PLAY, POINT, HOLD, DONE)
  - side typedef (LEFT = 0, RIGHT = 1)
  - default WIN_SCORE and HOLD_CYCLES constants
- Sub-module tug_hold_timer: loadable down-counter with a done flag, reused for HOLD and for the auto-restart delay.
- The FSM and scoring stay in tug_match_ctrl.

Test Plan:
- Reset, then lit_r = 1 and key_r pulsed once -> inc_r single 1-cycle pulse, score_r = 1, field_reset high for 4 cycles, then back in PLAY.
- key_l pulsed while lit_l = 0 and lit_r = 1 -> no inc pulse, scores unchanged.
- lit_l = lit_r = 1 with key_l = key_r = 1 in the same cycle -> no point; PLAY retained.
- Key presses during HOLD with lights lit -> ignored; no inc pulse until PLAY resumes.
- Seven left points -> 7 inc_l pulses, score_l = 7, match_over = 1, winner = 0. Further lit_l & key_l produces nothing.
- reset asserted during HOLD with score_r = 3 -> next cycle state PLAY, score_r = 0, field_reset = 0.
- With the macro defined, after a match win -> clear_scores pulses once 64 cycles later, and scores read 0.
